// File: rtl/riscv_enc_pkg.sv
// Shared opcode constants, format enum and stage bundle for the
// RV64 instruction encoder.
package riscv_enc_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] BAD_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SYS,
        FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
    } s1_t;

    function automatic fmt_e classify(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_IMM, OP_JALR, OP_LOAD: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI:                   f = FMT_U;
            OP_JAL:                   f = FMT_J;
            OP_SYSTEM:                f = FMT_SYS;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational format packing and 64-bit signed immediate range check.
module imm_pack
    import riscv_enc_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [63:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    fmt_e        fmt;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        fits32;
    logic        in_range;
    logic [31:0] word;

    // A value fits N signed bits when every bit above N-1 copies bit N-1.
    assign fits12 = (imm_i[63:11] == {53{imm_i[11]}});
    assign fits13 = (imm_i[63:12] == {52{imm_i[12]}});
    assign fits21 = (imm_i[63:20] == {44{imm_i[20]}});
    assign fits32 = (imm_i[63:31] == {33{imm_i[31]}});

    always_comb begin
        fmt      = classify(opcode_i);
        word     = BAD_WORD;
        in_range = 1'b0;
        case (fmt)
            FMT_I: begin
                word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                in_range = fits12;
            end
            FMT_S: begin
                word = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:0], opcode_i};
                in_range = fits12;
            end
            FMT_B: begin
                word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
                in_range = fits13 & ~imm_i[0];
            end
            FMT_U: begin
                word = {imm_i[31:12], rd_i, opcode_i};
                in_range = fits32 & (imm_i[11:0] == 12'd0);
            end
            FMT_J: begin
                word = {imm_i[20], imm_i[10:1], imm_i[11],
                        imm_i[19:12], rd_i, opcode_i};
                in_range = fits21 & ~imm_i[0];
            end
            FMT_SYS: begin
                word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                in_range = (imm_i[63:1] == 63'd0);
            end
            default: begin
                word     = BAD_WORD;
                in_range = 1'b0;
            end
        endcase
    end

    always_comb begin
        instr_o = word;
        err_o   = 1'b0;
        if (fmt == FMT_BAD) begin
            instr_o = BAD_WORD;
            err_o   = 1'b1;
        end else if (!in_range) begin
            instr_o = NOP_WORD;
            err_o   = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV64 instruction encoder with transfer statistics.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [63:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] good_count,
    output logic [7:0]       err_count
);

    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [7:0]       errc_q, errc_d;

    logic        s2_adv;
    logic        accept;
    logic        fire;
    logic [31:0] pk_instr;
    logic        pk_err;

    imm_pack u_pack (
        .opcode_i (s1_q.opcode),
        .funct3_i (s1_q.funct3),
        .rd_i     (s1_q.rd),
        .rs1_i    (s1_q.rs1),
        .rs2_i    (s1_q.rs2),
        .imm_i    (s1_q.imm),
        .instr_o  (pk_instr),
        .err_o    (pk_err)
    );

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~reset & (~s1_valid_q | s2_adv);
    assign accept   = in_valid & in_ready;
    assign fire     = s2_valid_q & out_ready;

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = accept | (s1_valid_q & ~s2_adv);
        if (accept) begin
            s1_d.opcode = opcode;
            s1_d.funct3 = funct3;
            s1_d.rd     = rd;
            s1_d.rs1    = rs1;
            s1_d.rs2    = rs2;
            s1_d.imm    = imm;
        end
    end

    // S2 holds its word while stalled; it only reloads when it can advance.
    always_comb begin
        s2_valid_d = s2_valid_q;
        instr_d    = instr_q;
        err_d      = err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = pk_instr;
                err_d   = pk_err;
            end
        end
    end

    always_comb begin
        good_d = good_q;
        errc_d = errc_q;
        if (fire) begin
            if (err_q) begin
                if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
            end else begin
                good_d = good_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
            good_q     <= '0;
            errc_q     <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            good_q     <= good_d;
            errc_q     <= errc_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign instr      = instr_q;
    assign err        = err_q;
    assign good_count = good_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] good_count;
    logic [7:0]  err_count;

    int checks;
    int errors;
    int good_exp;
    int errc_exp;

    instr_encoder #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .err        (err),
        .good_count (good_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [6:0] op,
                           input logic [2:0] f3, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [63:0] im,
                           input logic [31:0] exp_instr,
                           input logic exp_err);
        int n;
        @(negedge clk);
        opcode    = op;
        funct3    = f3;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        imm       = im;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 2);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_err"}, err, exp_err);
        if (exp_err) begin
            if (errc_exp < 255) errc_exp++;
        end else begin
            good_exp++;
        end
        @(negedge clk);
        check({tag, "_good"}, good_count, good_exp);
        check({tag, "_errc"}, err_count, errc_exp);
    endtask

    initial begin
        logic [63:0] t;
        logic [31:0] exp_w [10];
        int tx;
        int rx;
        int stalls;
        int g0;

        checks    = 0;
        errors    = 0;
        good_exp  = 0;
        errc_exp  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        funct3    = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        imm       = '0;

        repeat (2) @(negedge clk);
        check("rst_inrdy", in_ready, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_err", err, 0);
        check("rst_good", good_count, 0);
        check("rst_errc", err_count, 0);
        reset = 1'b0;

        run_one("addi", 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0,
                64'd5, 32'h00500093, 1'b0);
        run_one("sw", 7'b0100011, 3'b010, 5'd0, 5'd1, 5'd2,
                64'd8, 32'h0020A423, 1'b0);
        run_one("beq", 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2,
                -64'sd4, 32'hFE208EE3, 1'b0);
        run_one("lui", 7'b0110111, 3'b000, 5'd5, 5'd0, 5'd0,
                64'h12345000, 32'h123452B7, 1'b0);
        run_one("jal", 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0,
                64'd2048, 32'h001000EF, 1'b0);
        run_one("i_ovf", 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0,
                64'd2048, 32'h00000013, 1'b1);
        run_one("b_odd", 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2,
                64'd3, 32'h00000013, 1'b1);
        run_one("badop", 7'b0110011, 3'b000, 5'd1, 5'd2, 5'd3,
                64'd0, 32'h00000000, 1'b1);
        run_one("i_min", 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0,
                -64'sd2048, 32'h80000093, 1'b0);
        run_one("i_max", 7'b0000011, 3'b000, 5'd1, 5'd0, 5'd0,
                64'd2047, 32'h7FF00083, 1'b0);
        run_one("b_max", 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0,
                64'd4094, 32'h7E000FE3, 1'b0);
        run_one("b_ovf", 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0,
                64'd4096, 32'h00000013, 1'b1);
        run_one("u_neg", 7'b0110111, 3'b000, 5'd0, 5'd0, 5'd0,
                64'hFFFF_FFFF_8000_0000, 32'h80000037, 1'b0);
        run_one("u_ovf", 7'b0110111, 3'b000, 5'd0, 5'd0, 5'd0,
                64'h0000_0000_8000_0000, 32'h00000013, 1'b1);
        run_one("u_low", 7'b0110111, 3'b000, 5'd0, 5'd0, 5'd0,
                64'h12345001, 32'h00000013, 1'b1);
        run_one("j_min", 7'b1101111, 3'b000, 5'd0, 5'd0, 5'd0,
                -64'sd1048576, 32'h8000006F, 1'b0);
        run_one("j_ovf", 7'b1101111, 3'b000, 5'd0, 5'd0, 5'd0,
                64'd1048576, 32'h00000013, 1'b1);
        run_one("ebreak", 7'b1110011, 3'b000, 5'd0, 5'd0, 5'd0,
                64'd1, 32'h00100073, 1'b0);
        run_one("sys_ovf", 7'b1110011, 3'b000, 5'd0, 5'd0, 5'd0,
                64'd2, 32'h00000013, 1'b1);

        // streaming: 10 addi words, consumer ready toggles every cycle
        for (int i = 0; i < 10; i++) begin
            t = 64'(i * 100 - 300);
            exp_w[i] = {t[11:0], 5'(i), 3'b000, 5'(i + 1), 7'b0010011};
        end
        g0     = good_exp;
        tx     = 0;
        rx     = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 80 && rx < 10; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 2 == 0);
            if (tx < 10) begin
                opcode   = 7'b0010011;
                funct3   = 3'b000;
                rd       = 5'(tx + 1);
                rs1      = 5'(tx);
                rs2      = 5'd0;
                imm      = 64'(tx * 100 - 300);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                check("strm_instr", instr, exp_w[rx]);
                check("strm_err", err, 0);
                if (out_ready) rx++;
                else stalls++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        good_exp  = g0 + 10;
        @(negedge clk);
        check("strm_rx", rx, 10);
        check("strm_tx", tx, 10);
        check("strm_stalled", stalls > 0, 1);
        check("strm_good", good_count, good_exp);
        check("strm_idle", out_valid, 0);

        // reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        opcode    = 7'b0010011;
        funct3    = 3'b000;
        rd        = 5'd7;
        rs1       = 5'd0;
        imm       = 64'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        rd = 5'd8;
        #1 check("full_rdy1", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_ovalid", out_valid, 1);
        check("full_inrdy", in_ready, 0);
        reset = 1'b1;
        #1 check("rst2_inrdy", in_ready, 0);
        @(negedge clk);
        check("rst2_ovalid", out_valid, 0);
        check("rst2_instr", instr, 0);
        check("rst2_good", good_count, 0);
        check("rst2_errc", err_count, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        good_exp  = 0;
        errc_exp  = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst2_nostale", out_valid, 0);
        end
        check("rst2_good_idle", good_count, 0);
        run_one("post_rst", 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0,
                64'd5, 32'h00500093, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the good-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-006 SHALL have ports opcode input 7, funct3 input 3, rd input 5, rs1 input 5, rs2 input 5  instruction fields.
REQ-007 SHALL have port imm  input  64  signed immediate value to encode.
REQ-008 SHALL have port out_valid  output  1  encoded word present.
REQ-009 SHALL have port out_ready  input  1  word consumed when out_valid & out_ready.
REQ-010 SHALL have port instr  output  32  encoded RV64 instruction word.
REQ-011 SHALL have port err  output  1  qualifies instr; immediate out of range or opcode unsupported.
REQ-012 SHALL have ports good_count output CNT_W and err_count output 8  transfer statistics.

Function
REQ-013 SHALL be a 2-stage pipeline: S1 registers fields, classifies format and checks range; S2 holds packed instr/err.
REQ-014 SHALL give 2-cycle latency, accept to out_valid, with out_ready held high; 1 word per cycle throughput.
REQ-015 SHALL drive in_ready = !S1_valid | !S2_valid | out_ready (combinational); S1 advances into S2 when S2 empty or draining.
REQ-016 SHALL hold instr/err stable while out_valid & !out_ready.
REQ-017 SHALL map formats: I = 0010011, 1100111, 0000011; S = 0100011; B = 1100011; U = 0110111; J = 1101111; SYS = 1110011.
REQ-018 SHALL pack standard RISC-V layout: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; SYS as I.
REQ-019 SHALL range-check imm as 64-bit signed: I/S in [-2048,2047]; B in [-4096,4094] and imm[0]=0; J in [-2^20,2^20-2] and imm[0]=0; U sign-extends from bit 31 and imm[11:0]=0; SYS imm is 0 or 1.
REQ-020 SHALL, on a range failure, output err=1 and instr=32'h00000013 (NOP).
REQ-021 SHALL, on an unsupported opcode, output err=1 and instr=32'h00000000.
REQ-022 SHALL increment good_count on each output transfer with err=0 and wrap at 2^CNT_W.
REQ-023 SHALL increment err_count on each output transfer with err=1 and saturate at 255.
REQ-024 SHALL accept a new input and emit an output in the same cycle without loss or duplication.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, clear S1/S2 valid, out_valid, err, instr (0), good_count and err_count.
REQ-026 SHALL hold in_ready=0 during reset cycles; reset mid-stream discards in-flight words and does not count them.

Structure
REQ-027 SHALL place the opcode constants, format enum (FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_BAD) and NOP constant in a shared package riscv_enc_pkg.
REQ-028 SHALL implement packing and range checking in a combinational sub-module imm_pack; instr_encoder owns pipeline, handshake and counters.

Verification
REQ-029 SHALL cover: op 0010011, rd 1, rs1 0, f3 0, imm 5 -> instr 0x00500093, err 0, 2 cycles later.
REQ-030 SHALL cover: op 0100011, rs1 1, rs2 2, f3 010, imm 8 -> 0x0020A423; op 1100011, rs1 1, rs2 2, f3 0, imm -4 -> 0xFE208EE3.
REQ-031 SHALL cover: op 0110111, rd 5, imm 0x12345000 -> 0x123452B7; op 1101111, rd 1, imm 2048 -> 0x001000EF.
REQ-032 SHALL cover: I-type imm 2048 -> err 1, instr 0x00000013, err_count 1; B-type imm 3 -> err 1; opcode 0110011 -> err 1, instr 0.
REQ-033 SHALL cover: back-to-back stream of 10 words with out_ready toggling 1/0 -> 10 outputs in order, stable while stalled, good_count 10.
REQ-034 SHALL cover: reset asserted with both stages full -> next cycle out_valid 0, counters 0, no stale word after release.
